// File: rtl/lc3_pkg.sv
// Shared LC-3 decode constants and the operand-sequencer state type.
package lc3_pkg;

    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_STR = 4'b0111;

    localparam int OPC_LSB    = 12;
    localparam int SR1_LSB    = 6;
    localparam int STSRC_LSB  = 9;
    localparam int SR2_LSB    = 0;
    localparam int FIELD_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } rrs_state_t;

    // Stores read their data register from the DR/SR field instead of bits [2:0].
    function automatic logic [FIELD_W-1:0] sr2_field(input logic [15:0] instr);
        logic [3:0] opc;
        opc = instr[OPC_LSB +: 4];
        if (opc == OP_ST || opc == OP_STI || opc == OP_STR) begin
            return instr[STSRC_LSB +: FIELD_W];
        end
        return instr[SR2_LSB +: FIELD_W];
    endfunction

endpackage

// File: rtl/reg_read_sequencer.sv
// Register-file read initiator: issues source addresses, absorbs the one-cycle
// read latency, bypasses racing writebacks and hands operands to execute.
module reg_read_sequencer
    import lc3_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [15:0]       op_instr,
    output logic [DATA_W-1:0] op_sr1_data,
    output logic [DATA_W-1:0] op_sr2_data,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] rf_sr1,
    output logic [ADDR_W-1:0] rf_sr2,
    input  logic [DATA_W-1:0] rf_sr1_data,
    input  logic [DATA_W-1:0] rf_sr2_data,
    output logic [ADDR_W-1:0] rf_dst,
    output logic [DATA_W-1:0] rf_w_data,
    output logic              rf_w_en,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; a raised valid holds its payload until that edge.
    rrs_state_t state_q, state_d;

    logic [15:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] sr1_q, sr1_d, sr2_q, sr2_d;
    logic              byp1_q, byp1_d, byp2_q, byp2_d;
    logic [DATA_W-1:0] byp1_data_q, byp1_data_d, byp2_data_q, byp2_data_d;
    logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;

    logic [ADDR_W-1:0] sr1_idx, sr2_idx;
    logic              accept;
    logic              hit1_new, hit2_new, hit1_held, hit2_held;

    assign sr1_idx = ADDR_W'(in_instr[SR1_LSB +: FIELD_W]);
    assign sr2_idx = ADDR_W'(sr2_field(in_instr));

    assign rf_sr1    = sr1_idx;
    assign rf_sr2    = sr2_idx;
    assign rf_w_en   = wb_valid & rst_n;
    assign rf_dst    = wb_dst;
    assign rf_w_data = wb_data;

    assign accept    = in_valid & in_ready;
    assign hit1_new  = wb_valid && (wb_dst == sr1_idx);
    assign hit2_new  = wb_valid && (wb_dst == sr2_idx);
    assign hit1_held = wb_valid && (wb_dst == sr1_q);
    assign hit2_held = wb_valid && (wb_dst == sr2_q);

    assign op_instr    = instr_q;
    assign op_sr1_data = op1_q;
    assign op_sr2_data = op2_q;
    assign dbg_state   = state_q;

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        op_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = READ;
            end
            READ: state_d = HOLD;
            HOLD: begin
                op_valid = 1'b1;
                in_ready = op_ready;
                if (op_ready) state_d = in_valid ? READ : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        instr_d     = instr_q;
        sr1_d       = sr1_q;
        sr2_d       = sr2_q;
        byp1_d      = byp1_q;
        byp2_d      = byp2_q;
        byp1_data_d = byp1_data_q;
        byp2_data_d = byp2_data_q;
        op1_d       = op1_q;
        op2_d       = op2_q;

        // The register file returns the pre-write value on the accept edge,
        // so a write there is remembered and replayed at capture.
        if (accept) begin
            instr_d     = in_instr;
            sr1_d       = sr1_idx;
            sr2_d       = sr2_idx;
            byp1_d      = hit1_new;
            byp2_d      = hit2_new;
            byp1_data_d = wb_data;
            byp2_data_d = wb_data;
        end

        if (state_q == READ) begin
            op1_d = hit1_held ? wb_data : (byp1_q ? byp1_data_q : rf_sr1_data);
            op2_d = hit2_held ? wb_data : (byp2_q ? byp2_data_q : rf_sr2_data);
        end

        if (state_q == HOLD) begin
            if (hit1_held) op1_d = wb_data;
            if (hit2_held) op2_d = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            instr_q     <= '0;
            sr1_q       <= '0;
            sr2_q       <= '0;
            byp1_q      <= 1'b0;
            byp2_q      <= 1'b0;
            byp1_data_q <= '0;
            byp2_data_q <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            sr1_q       <= sr1_d;
            sr2_q       <= sr2_d;
            byp1_q      <= byp1_d;
            byp2_q      <= byp2_d;
            byp1_data_q <= byp1_data_d;
            byp2_data_q <= byp2_data_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
        end
    end

endmodule
